// File: rtl/alu_operand_register_file.sv
// rtl/alu_operand_register_file.sv - eight 16-bit load/inc/dec/clear registers with two combinational read ports
module alu_operand_register_file #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [3:0]       RegSel,
    input  logic [3:0]       ScrSel,
    input  logic [2:0]       OutASel,
    input  logic [2:0]       OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB
);

    typedef enum logic [2:0] {
        FN_DEC      = 3'b000,
        FN_INC      = 3'b001,
        FN_LOAD     = 3'b010,
        FN_CLEAR    = 3'b011,
        FN_CLR_LDLO = 3'b100,
        FN_LDLO     = 3'b101,
        FN_LDHI     = 3'b110,
        FN_SEXT_LO  = 3'b111
    } fun_t;

    // Index 0..3 = R1..R4, 4..7 = S1..S4, matching the read-select encoding.
    logic [WIDTH-1:0] regs [8];
    logic [7:0]       en;
    logic [WIDTH-1:0] nxt [8];

    assign en = {~ScrSel[0], ~ScrSel[1], ~ScrSel[2], ~ScrSel[3],
                 ~RegSel[0], ~RegSel[1], ~RegSel[2], ~RegSel[3]};

    function automatic logic [WIDTH-1:0] next_val(
        input logic [WIDTH-1:0] q,
        input logic [2:0]       fs,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] v;
        v = q;
        case (fun_t'(fs))
            FN_DEC:      v = q - 1'b1;
            FN_INC:      v = q + 1'b1;
            FN_LOAD:     v = d;
            FN_CLEAR:    v = '0;
            FN_CLR_LDLO: begin
                v      = '0;
                v[7:0] = d[7:0];
            end
            FN_LDLO:     v[7:0] = d[7:0];
            FN_LDHI:     v[15:8] = d[7:0];
            FN_SEXT_LO:  v = {{(WIDTH-8){d[7]}}, d[7:0]};
            default:     v = q;
        endcase
        return v;
    endfunction

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            nxt[k] = next_val(regs[k], FunSel, I);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 8; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (en[k]) begin
                    regs[k] <= nxt[k];
                end
            end
        end
    end

    // No write bypass: reads always reflect the registered contents.
    assign OutA = regs[OutASel];
    assign OutB = regs[OutBSel];

endmodule

// File: tb/tb_alu_operand_register_file.sv
// tb/tb_alu_operand_register_file.sv - randomized self-checking bench for alu_operand_register_file
module tb_alu_operand_register_file;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] I;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [15:0] OutA;
    logic [15:0] OutB;

    int checks = 0;
    int errors = 0;
    int m [8];

    alu_operand_register_file #(.WIDTH(16)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .I       (I),
        .FunSel  (FunSel),
        .RegSel  (RegSel),
        .ScrSel  (ScrSel),
        .OutASel (OutASel),
        .OutBSel (OutBSel),
        .OutA    (OutA),
        .OutB    (OutB)
    );

    always #5 Clock = ~Clock;

    function automatic int model_next(input int q, input int fs, input int d);
        int lo;
        lo = d % 256;
        case (fs)
            0: return (q + 65535) % 65536;
            1: return (q + 1) % 65536;
            2: return d;
            3: return 0;
            4: return lo;
            5: return (q / 256) * 256 + lo;
            6: return lo * 256 + q % 256;
            default: return (lo >= 128) ? 65280 + lo : lo;
        endcase
    endfunction

    function automatic bit model_enabled(input int k, input logic [3:0] rs, input logic [3:0] ss);
        if (k < 4) return rs[3-k] == 1'b0;
        return ss[7-k] == 1'b0;
    endfunction

    task automatic apply(input logic [2:0] fs, input logic [3:0] rs, input logic [3:0] ss, input logic [15:0] din);
        FunSel = fs;
        RegSel = rs;
        ScrSel = ss;
        I      = din;
        @(posedge Clock);
        for (int k = 0; k < 8; k++) begin
            if (model_enabled(k, rs, ss)) m[k] = model_next(m[k], int'(fs), int'(din));
        end
        @(negedge Clock);
        RegSel = 4'hF;
        ScrSel = 4'hF;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 8; k++) begin
            OutASel = 3'(k);
            OutBSel = 3'(7 - k);
            #1;
            checks++;
            if (OutA !== 16'h0000 || OutB !== 16'h0000) begin
                $display("FAIL reset_state sel=%0d: OutA=%h OutB=%h required 0000", k, OutA, OutB);
                errors++;
            end
        end
        @(negedge Clock);
        Reset = 1'b0;
        apply(3'b010, 4'b0111, 4'hF, 16'h1234);
        apply(3'b010, 4'hF, 4'b1110, 16'hBEEF);
        OutASel = 3'd0;
        OutBSel = 3'd7;
        #1;
        checks++;
        if (OutA !== 16'h1234 || OutB !== 16'hBEEF) begin
            $display("FAIL reset_preload: OutA=%h OutB=%h required 1234/BEEF", OutA, OutB);
            errors++;
        end
        #1;
        Reset = 1'b1;
        #1;
        checks++;
        if (OutA !== 16'h0000 || OutB !== 16'h0000) begin
            $display("FAIL reset_async: OutA=%h OutB=%h required 0000", OutA, OutB);
            errors++;
        end
        FunSel = 3'b010;
        RegSel = 4'h0;
        ScrSel = 4'h0;
        I      = 16'hFFFF;
        @(posedge Clock);
        @(posedge Clock);
        @(negedge Clock);
        for (int k = 0; k < 8; k++) m[k] = 0;
        for (int k = 0; k < 8; k++) begin
            OutASel = 3'(k);
            #1;
            checks++;
            if (OutA !== 16'h0000) begin
                $display("FAIL reset_priority sel=%0d: OutA=%h required 0000", k, OutA);
                errors++;
            end
        end
        RegSel = 4'hF;
        ScrSel = 4'hF;
        @(negedge Clock);
        Reset = 1'b0;
        apply(3'b010, 4'b0111, 4'hF, 16'h0055);
        OutASel = 3'd0;
        #1;
        checks++;
        if (OutA !== 16'h0055) begin
            $display("FAIL reset_resume: OutA=%h required 0055", OutA);
            errors++;
        end
        apply(3'b011, 4'b0111, 4'hF, 16'h0000);
    endtask

    task automatic test_load();
        OutASel = 3'd0;
        FunSel  = 3'b010;
        RegSel  = 4'b0111;
        ScrSel  = 4'hF;
        I       = 16'hA5C3;
        #1;
        checks++;
        if (OutA !== 16'h0000) begin
            $display("FAIL load_no_bypass: OutA=%h required 0000", OutA);
            errors++;
        end
        @(negedge Clock);
        apply(3'b010, 4'b0111, 4'hF, 16'hA5C3);
        #1;
        checks++;
        if (OutA !== 16'hA5C3) begin
            $display("FAIL load_r1: OutA=%h required A5C3", OutA);
            errors++;
        end
        for (int k = 1; k < 8; k++) begin
            OutBSel = 3'(k);
            #1;
            checks++;
            if (OutB !== 16'h0000) begin
                $display("FAIL load_others sel=%0d: OutB=%h required 0000", k, OutB);
                errors++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_tab [3];
        logic [2:0]  fs_tab [3];
        exp_tab = '{16'h0000, 16'hFFFF, 16'hFFFE};
        fs_tab  = '{3'b001, 3'b000, 3'b000};
        @(negedge Clock);
        apply(3'b010, 4'b1011, 4'hF, 16'hFFFF);
        OutASel = 3'd1;
        for (int s = 0; s < 3; s++) begin
            apply(fs_tab[s], 4'b1011, 4'hF, 16'h1357);
            #1;
            checks++;
            if (OutA !== exp_tab[s] || int'(OutA) != m[1]) begin
                $display("FAIL wrap step=%0d: R2=%h required %h", s, OutA, exp_tab[s]);
                errors++;
            end
        end
    endtask

    task automatic test_byte_ops();
        logic [2:0]  fs_tab [5];
        logic [15:0] in_tab [5];
        logic [15:0] exp_tab [5];
        fs_tab  = '{3'b101, 3'b110, 3'b100, 3'b111, 3'b111};
        in_tab  = '{16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0, 16'h0070};
        exp_tab = '{16'h12F0, 16'hF0F0, 16'h00F0, 16'hFFF0, 16'h0070};
        @(negedge Clock);
        apply(3'b010, 4'hF, 4'b1011, 16'h1234);
        OutBSel = 3'd5;
        for (int s = 0; s < 5; s++) begin
            apply(fs_tab[s], 4'hF, 4'b1011, in_tab[s]);
            #1;
            checks++;
            if (OutB !== exp_tab[s] || int'(OutB) != m[5]) begin
                $display("FAIL byte_op step=%0d: S2=%h required %h", s, OutB, exp_tab[s]);
                errors++;
            end
        end
    endtask

    task automatic test_multi_enable();
        @(negedge Clock);
        apply(3'b010, 4'b0111, 4'hF, 16'h0005);
        apply(3'b010, 4'b1101, 4'hF, 16'hFFFF);
        apply(3'b010, 4'hF, 4'b0111, 16'h0007);
        apply(3'b001, 4'b0101, 4'b0111, 16'h0000);
        OutASel = 3'd0;
        OutBSel = 3'd2;
        #1;
        checks++;
        if (OutA !== 16'h0006 || OutB !== 16'h0000) begin
            $display("FAIL multi_r1_r3: R1=%h R3=%h required 0006/0000", OutA, OutB);
            errors++;
        end
        OutASel = 3'd4;
        #1;
        checks++;
        if (OutA !== 16'h0008) begin
            $display("FAIL multi_s1: S1=%h required 0008", OutA);
            errors++;
        end
        for (int k = 0; k < 8; k++) begin
            OutBSel = 3'(k);
            #1;
            checks++;
            if (int'(OutB) != m[k]) begin
                $display("FAIL multi_model sel=%0d: got %h required %h", k, OutB, 16'(m[k]));
                errors++;
            end
        end
    endtask

    task automatic test_dual_read();
        @(negedge Clock);
        apply(3'b010, 4'hF, 4'b1011, 16'h4242);
        OutASel = 3'd5;
        OutBSel = 3'd5;
        #1;
        checks++;
        if (OutA !== 16'h4242 || OutB !== 16'h4242) begin
            $display("FAIL dual_read: OutA=%h OutB=%h required 4242", OutA, OutB);
            errors++;
        end
    endtask

    task automatic test_random();
        logic [2:0]  fs;
        logic [3:0]  rs;
        logic [3:0]  ss;
        logic [15:0] din;
        @(negedge Clock);
        for (int n = 0; n < 60; n++) begin
            fs  = 3'($urandom_range(0, 7));
            rs  = 4'($urandom);
            ss  = 4'($urandom);
            din = 16'($urandom);
            // Mid-cycle glitch on all controls must leave state alone.
            FunSel = 3'($urandom);
            RegSel = 4'h0;
            ScrSel = 4'h0;
            I      = 16'($urandom);
            #1;
            apply(fs, rs, ss, din);
            if (n % 15 == 14) begin
                for (int a = 0; a < 8; a++) begin
                    for (int b = 0; b < 8; b++) begin
                        OutASel = 3'(a);
                        OutBSel = 3'(b);
                        #1;
                        checks++;
                        if (int'(OutA) != m[a] || int'(OutB) != m[b]) begin
                            $display("FAIL sweep a=%0d b=%0d: OutA=%h OutB=%h required %h/%h",
                                     a, b, OutA, OutB, 16'(m[a]), 16'(m[b]));
                            errors++;
                        end
                    end
                end
                @(negedge Clock);
            end else begin
                OutASel = 3'($urandom);
                OutBSel = 3'($urandom);
                #1;
                checks++;
                if (int'(OutA) != m[OutASel] || int'(OutB) != m[OutBSel]) begin
                    $display("FAIL random n=%0d: OutA=%h OutB=%h required %h/%h",
                             n, OutA, OutB, 16'(m[OutASel]), 16'(m[OutBSel]));
                    errors++;
                end
                @(negedge Clock);
            end
        end
    endtask

    initial begin
        Reset   = 1'b1;
        I       = 16'h0000;
        FunSel  = 3'b000;
        RegSel  = 4'hF;
        ScrSel  = 4'hF;
        OutASel = 3'd0;
        OutBSel = 3'd0;
        for (int k = 0; k < 8; k++) m[k] = 0;
        #12;
        test_reset();
        test_load();
        test_wrap();
        test_byte_ops();
        test_multi_enable();
        test_dual_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
